tdm_mux_16x1: RTL and testbench

TDM_MUX_16X1 -- requirements
Module: tdm_mux_16x1

---
 rtl/tdm_mux_16x1.sv | 177 +++++++++++++++++
 tb/tb_tdm_mux_16x1.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tdm_mux_16x1.sv
`timescale 1ns / 1ps
// -----------------------------------------------------------------------------
// tdm_mux_16x1
//
// Serialises 16-bit words into 16 TDM slots, LSB first. A one-deep pending
// buffer takes words at any time. A separate active register holds the frame
// that is being sent. Between frames FRAME_GAP idle cycles are inserted
// (0..15). With FRAME_GAP=0, frames run back to back. The enable gates only
// the start of a new frame. A frame that is already running always finishes.
//
// Ports
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   en          run enable (gates frame starts only)
//   data_in_16  word to serialise
//   load_valid  data_in_16 holds a word
//   load_ready  pending buffer empty, so a word can be accepted
//   data_out    serial bit of the current slot (registered)
//   select_4    slot index 0..15 of data_out (registered)
//   valid_out   data_out/select_4 carry a live slot (registered)
//   frame_start high during slot 0 of every frame (registered)
// -----------------------------------------------------------------------------
module tdm_mux_16x1 #(
  parameter int unsigned FRAME_GAP = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [15:0] data_in_16,
  input  logic        load_valid,
  output logic        load_ready,
  output logic        data_out,
  output logic [3:0]  select_4,
  output logic        valid_out,
  output logic        frame_start
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } state_t;

  localparam logic [3:0] LAST_SLOT = 4'd15;
  localparam bit         HAS_GAP   = (FRAME_GAP != 0);
  // The gap counter counts down to zero. Its last value marks the final gap edge.
  localparam logic [3:0] GAP_LOAD  = HAS_GAP ? 4'(FRAME_GAP - 1) : 4'd0;

  state_t      state, state_next;
  logic [3:0]  slot, slot_next;
  logic [3:0]  gap_cnt, gap_cnt_next;
  logic [15:0] pending, pending_next;
  logic        pending_full, pending_full_next;
  logic [15:0] active, active_next;
  logic        data_out_next;
  logic [3:0]  select_next;
  logic        valid_next;
  logic        frame_start_next;

  logic        accept;
  logic        start_point;
  logic        start;
  logic [3:0]  slot_inc;

  assign load_ready = !pending_full;
  assign accept     = load_valid && !pending_full;
  assign start      = start_point && en && pending_full;
  assign slot_inc   = slot + 4'd1;

  // A new frame may begin only at these edges: any edge in IDLE, the last
  // slot edge when frames run back to back, or the final edge of the gap.
  always_comb begin
    start_point = 1'b0;
    case (state)
      IDLE:    start_point = 1'b1;
      SEND:    start_point = !HAS_GAP && (slot == LAST_SLOT);
      GAP:     start_point = (gap_cnt == 4'd0);
      default: start_point = 1'b0;
    endcase
  end

  // Next-state logic and next registered outputs.
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    state_next       = state;
    slot_next        = slot;
    gap_cnt_next     = gap_cnt;
    active_next      = active;
    data_out_next    = 1'b0;
    select_next      = 4'd0;
    valid_next       = 1'b0;
    frame_start_next = 1'b0;

    if (start) begin
      // The pending word moves to active, and slot 0 appears on the outputs at once.
      state_next       = SEND;
      slot_next        = 4'd0;
      gap_cnt_next     = 4'd0;
      active_next      = pending;
      data_out_next    = pending[0];
      valid_next       = 1'b1;
      frame_start_next = 1'b1;
    end else begin
      case (state)
        SEND: begin
          if (slot != LAST_SLOT) begin
            slot_next     = slot_inc;
            select_next   = slot_inc;
            data_out_next = active[slot_inc];
            valid_next    = 1'b1;
          end else begin
            slot_next = 4'd0;
            if (HAS_GAP) begin
              state_next   = GAP;
              gap_cnt_next = GAP_LOAD;
            end else begin
              state_next = IDLE;
            end
          end
        end
        GAP: begin
          if (gap_cnt == 4'd0) begin
            state_next = IDLE;
          end else begin
            gap_cnt_next = gap_cnt - 4'd1;
          end
        end
        default: begin
          state_next = state;
        end
      endcase
    end
  end

  // Pending buffer. It is freed by a start and refilled by an acceptance in
  // the same cycle.
  always_comb begin
    pending_next      = pending;
    pending_full_next = pending_full;
    if (start) begin
      pending_full_next = 1'b0;
    end
    if (accept) begin
      pending_next      = data_in_16;
      pending_full_next = 1'b1;
    end
  end

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the word registers are reset too, so an aborted frame leaves no stale data behind.
      state        <= IDLE;
      slot         <= 4'd0;
      gap_cnt      <= 4'd0;
      pending      <= 16'd0;
      pending_full <= 1'b0;
      active       <= 16'd0;
      data_out     <= 1'b0;
      select_4     <= 4'd0;
      valid_out    <= 1'b0;
      frame_start  <= 1'b0;
    end else begin
      state        <= state_next;
      slot         <= slot_next;
      gap_cnt      <= gap_cnt_next;
      pending      <= pending_next;
      pending_full <= pending_full_next;
      active       <= active_next;
      data_out     <= data_out_next;
      select_4     <= select_next;
      valid_out    <= valid_next;
      frame_start  <= frame_start_next;
    end
  end

endmodule

// File: tb/tb_tdm_mux_16x1.sv
`timescale 1ns / 1ps
// -----------------------------------------------------------------------------
// tb_tdm_mux_16x1
//
// Three instances share one set of inputs: FRAME_GAP = 1, 0 and 3.
// A frame-level reference model runs beside the DUTs and is compared on every
// cycle. Directed sequences cover the single-frame table, back-to-back
// frames, back-pressure, the enable drop, the gap length and reset mid-frame.
// -----------------------------------------------------------------------------
module tb_tdm_mux_16x1;

  localparam int N_DUT = 3;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              en;
  logic              load_valid;
  logic [15:0]       data_in_16;
  logic [N_DUT-1:0]  load_ready;
  logic [N_DUT-1:0]  data_out;
  logic [N_DUT-1:0]  valid_out;
  logic [N_DUT-1:0]  frame_start;
  logic [3:0]        select_4 [N_DUT];

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < N_DUT; g++) begin : g_dut
    tdm_mux_16x1 #(
      .FRAME_GAP((g == 0) ? 1 : ((g == 1) ? 0 : 3))
    ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .en         (en),
      .data_in_16 (data_in_16),
      .load_valid (load_valid),
      .load_ready (load_ready[g]),
      .data_out   (data_out[g]),
      .select_4   (select_4[g]),
      .valid_out  (valid_out[g]),
      .frame_start(frame_start[g])
    );
  end

  function automatic int gap_of(int i);
    return (i == 0) ? 1 : ((i == 1) ? 0 : 3);
  endfunction

  // ---------------------------------------------------------------------------
  // Reference model: one frame is a run of 16 + gap cycles, counted by phase.
  // Phases 0..15 are live slots and the rest are idle gap cycles. A new frame
  // may begin when the model is not busy, or on the last phase of the run.
  // ---------------------------------------------------------------------------
  typedef struct {
    bit          busy;
    int          phase;
    logic [15:0] act;
    logic [15:0] pend;
    bit          pfull;
  } model_t;

  model_t m [N_DUT];

  function automatic void model_reset();
    for (int i = 0; i < N_DUT; i++) begin
      m[i].busy  = 1'b0;
      m[i].phase = 0;
      m[i].act   = 16'd0;
      m[i].pend  = 16'd0;
      m[i].pfull = 1'b0;
    end
  endfunction

  function automatic void model_step(int i, bit en_s, bit lv_s, logic [15:0] din_s);
    int last;
    bit acc;
    bit at_start;
    last     = 15 + gap_of(i);
    acc      = lv_s && !m[i].pfull;
    at_start = !m[i].busy || (m[i].phase == last);
    if (at_start && en_s && m[i].pfull) begin
      m[i].act   = m[i].pend;
      m[i].pfull = 1'b0;
      m[i].busy  = 1'b1;
      m[i].phase = 0;
    end else if (m[i].busy) begin
      if (m[i].phase == last) m[i].busy = 1'b0;
      else                    m[i].phase++;
    end
    if (acc) begin
      m[i].pend  = din_s;
      m[i].pfull = 1'b1;
    end
  endfunction

  // Packed as {load_ready, data_out, select_4, valid_out, frame_start}.
  function automatic logic [7:0] model_out(int i);
    bit         live;
    logic [3:0] s;
    bit         d;
    live = m[i].busy && (m[i].phase < 16);
    s    = live ? 4'(m[i].phase) : 4'd0;
    d    = live ? m[i].act[m[i].phase[3:0]] : 1'b0;
    return {!m[i].pfull, d, s, live, live && (m[i].phase == 0)};
  endfunction

  function automatic logic [7:0] dut_out(int i);
    return {load_ready[i], data_out[i], select_4[i], valid_out[i], frame_start[i]};
  endfunction

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual === expected) n_pass++;
    else $display("FAIL %s: got %h, want %h", name, actual, expected);
  endtask

  // Words that instance 0 emits, reassembled from its serial output.
  logic [15:0] asm0;
  logic [15:0] frames0 [$];

  // One clock: the model takes the inputs seen at the edge, and the outputs
  // are compared 1 ns later.
  task automatic tick();
    @(posedge clk);
    for (int i = 0; i < N_DUT; i++) model_step(i, en, load_valid, data_in_16);
    #1;
    for (int i = 0; i < N_DUT; i++)
      check($sformatf("cycle_i%0d", i), 32'(dut_out(i)), 32'(model_out(i)));
    if (valid_out[0]) begin
      asm0[select_4[0]] = data_out[0];
      if (select_4[0] == 4'd15) frames0.push_back(asm0);
    end
  endtask

  task automatic idle(input int n);
    load_valid = 1'b0;
    repeat (n) tick();
  endtask

  typedef struct {
    bit          en;
    bit          lv;
    logic [15:0] din;
    bit          e_valid;
    logic [3:0]  e_sel;
    bit          e_dout;
    bit          e_fs;
    bit          e_ready;
  } vec_t;

  function automatic vec_t mk(bit en_v, bit lv_v, logic [15:0] din_v, bit v,
                              logic [3:0] s, bit d, bit f, bit r);
    vec_t x;
    x.en = en_v; x.lv = lv_v; x.din = din_v;
    x.e_valid = v; x.e_sel = s; x.e_dout = d; x.e_fs = f; x.e_ready = r;
    return x;
  endfunction

  vec_t vecs [19];
  bit   exp_bits [16];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          lowcnt;
    int          gapcnt;
    bit          r;
    bit          found;
    logic [15:0] words [3];

    // Stimulus table for one FRAME_GAP=1 frame carrying 16'hA5C3.
    exp_bits = '{1, 1, 0, 0, 0, 0, 1, 1, 1, 0, 1, 0, 0, 1, 0, 1};
    vecs[0] = mk(1'b1, 1'b1, 16'hA5C3, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 16; k++)
      vecs[k+1] = mk(1'b1, 1'b0, 16'h0000, 1'b1, 4'(k), exp_bits[k], (k == 0), 1'b1);
    vecs[17] = mk(1'b1, 1'b0, 16'h0000, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
    vecs[18] = mk(1'b1, 1'b0, 16'h0000, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1);

    // Reset state.
    rst_n = 1'b0; en = 1'b0; load_valid = 1'b0; data_in_16 = 16'h0000;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    for (int i = 0; i < N_DUT; i++)
      check($sformatf("reset_state_i%0d", i), 32'(dut_out(i)), 32'h80);

    // Single frame with a one-cycle acceptance-to-slot-0 latency.
    for (int i = 0; i < 19; i++) begin
      en = vecs[i].en; load_valid = vecs[i].lv; data_in_16 = vecs[i].din;
      tick();
      check($sformatf("vec%0d", i),
            32'({load_ready[0], data_out[0], select_4[0], valid_out[0], frame_start[0]}),
            32'({vecs[i].e_ready, vecs[i].e_dout, vecs[i].e_sel, vecs[i].e_valid, vecs[i].e_fs}));
    end
    idle(5);

    // Back-to-back frames on FRAME_GAP=0: FFFF then 0000 without an idle cycle.
    load_valid = 1'b1; data_in_16 = 16'hFFFF;
    tick();
    data_in_16 = 16'h0000;
    for (int i = 0; i < 32; i++) begin
      tick();
      if (i == 1) load_valid = 1'b0;
      check($sformatf("b2b_i1_c%0d", i),
            32'({valid_out[1], frame_start[1], data_out[1], select_4[1]}),
            32'({1'b1, (i == 0) || (i == 16), (i < 16), 4'(i % 16)}));
    end
    tick();
    check("b2b_i1_end_valid", 32'(valid_out[1]), 32'd0);
    idle(30);

    // Back-pressure: a held third word is accepted exactly once.
    frames0.delete();
    words = '{16'h1234, 16'hBEEF, 16'h0F0F};
    load_valid = 1'b1; data_in_16 = words[0];
    tick();
    data_in_16 = words[1];
    tick();
    tick();
    data_in_16 = words[2];
    lowcnt = 0;
    found  = 1'b0;
    for (int g = 0; g < 60 && !found; g++) begin
      r = load_ready[0];
      tick();
      if (r) found = 1'b1;
      else   lowcnt++;
    end
    load_valid = 1'b0;
    check("bp_accepted", 32'(found), 32'd1);
    check("bp_ready_low_cycles", lowcnt, 16);
    idle(45);
    check("bp_frame_count", frames0.size(), 3);
    for (int i = 0; i < 3; i++)
      if (i < frames0.size()) check($sformatf("bp_frame%0d", i), 32'(frames0[i]), 32'(words[i]));
    idle(10);

    // Enable dropped at slot 5 while a word is pending.
    words = '{16'h8001, 16'h3C5A, 16'h0000};
    load_valid = 1'b1; data_in_16 = words[0];
    tick();
    data_in_16 = words[1];
    tick();
    tick();
    load_valid = 1'b0;
    repeat (4) tick();
    check("en_at_slot5", 32'(select_4[0]), 32'd5);
    en = 1'b0;
    for (int k = 6; k < 16; k++) begin
      tick();
      check($sformatf("en_low_slot%0d", k), 32'({valid_out[0], select_4[0]}), 32'({1'b1, 4'(k)}));
    end
    lowcnt = 0;
    repeat (20) begin
      tick();
      if (valid_out[0] || load_ready[0]) lowcnt++;
    end
    check("en_low_no_frame_word_kept", lowcnt, 0);
    en = 1'b1;
    tick();
    check("en_restart", 32'({valid_out[0], frame_start[0], select_4[0], data_out[0]}),
          32'({1'b1, 1'b1, 4'd0, words[1][0]}));
    idle(25);

    // FRAME_GAP=3: exactly three idle cycles between slot 15 and the next frame.
    load_valid = 1'b1; data_in_16 = 16'h5555;
    tick();
    data_in_16 = 16'hAAAA;
    tick();
    tick();
    load_valid = 1'b0;
    found = 1'b0;
    for (int g = 0; g < 40 && !found; g++) begin
      tick();
      if (valid_out[2] && select_4[2] == 4'd15) found = 1'b1;
    end
    check("gap3_slot15_seen", 32'(found), 32'd1);
    gapcnt = 0;
    found  = 1'b0;
    for (int g = 0; g < 20 && !found; g++) begin
      tick();
      if (frame_start[2]) found = 1'b1;
      else if (!valid_out[2]) gapcnt++;
    end
    check("gap3_next_frame", 32'(found), 32'd1);
    check("gap3_idle_cycles", gapcnt, 3);
    idle(25);

    // Reset at slot 7 with a second word pending.
    load_valid = 1'b1; data_in_16 = 16'hC0DE;
    tick();
    data_in_16 = 16'hFACE;
    tick();
    tick();
    load_valid = 1'b0;
    repeat (6) tick();
    check("rst_at_slot7", 32'({valid_out[0], select_4[0]}), 32'({1'b1, 4'd7}));
    #2;
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < N_DUT; i++)
      check($sformatf("rst_async_i%0d", i),
            32'({valid_out[i], select_4[i], data_out[i], load_ready[i], frame_start[i]}),
            32'({1'b0, 4'd0, 1'b0, 1'b1, 1'b0}));
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    lowcnt = 0;
    repeat (25) begin
      tick();
      if (valid_out != '0) lowcnt++;
    end
    check("rst_nothing_emitted", lowcnt, 0);

    // Randomised traffic against the model.
    for (int c = 0; c < 1500; c++) begin
      en         = ($urandom_range(0, 9) != 0);
      load_valid = ($urandom_range(0, 1) == 1);
      data_in_16 = 16'($urandom);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
